// File: rtl/shiftleft_iterative.sv
// Multi-cycle logical left shifter: one power-of-two stage per clock (MSB stage first), start/ready handshake.
// Optional SHIFTLEFT_OVF_EN adds data_exception, flagging any 1 bit shifted out past the MSB.
module shiftleft_iterative #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ctrl_shift,
    input  logic [DATA_WIDTH-1:0]  data_operand,
    input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
    output logic [DATA_WIDTH-1:0]  data_result,
    output logic                   data_resultRDY,
    output logic                   busy
`ifdef SHIFTLEFT_OVF_EN
    ,
    output logic                   data_exception
`endif
);

    localparam int K_W = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
    localparam int K_N = 1 << K_W;
    localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_WIDTH-1:0]  amt_q, amt_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    start_accept;

    // Candidate outputs of every stage; the stage counter picks the active one.
    // Counter codes beyond the last stage map to a plain hold.
    logic [DATA_WIDTH-1:0]   stage_val [K_N];
    logic [DATA_WIDTH-1:0]   stage_sel;

`ifdef SHIFTLEFT_OVF_EN
    logic [K_N-1:0]          stage_loss;
    logic                    loss_q, loss_d;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < K_N; gi++) begin : g_stage
            if (gi < SHAMT_WIDTH) begin : g_real
                localparam int STEP = 1 << gi;
                assign stage_val[gi] = amt_q[gi] ? (work_q << STEP) : work_q;
`ifdef SHIFTLEFT_OVF_EN
                // Bits about to fall off the top in this stage.
                assign stage_loss[gi] = amt_q[gi] & (|work_q[DATA_WIDTH-1 -: STEP]);
`endif
            end else begin : g_pad
                assign stage_val[gi] = work_q;
`ifdef SHIFTLEFT_OVF_EN
                assign stage_loss[gi] = 1'b0;
`endif
            end
        end
    endgenerate

    assign stage_sel    = stage_val[k_q];
    assign start_accept = ctrl_shift && (state_q != S_SHIFT);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ctrl_shift) state_d = S_SHIFT;
            S_SHIFT: if (k_q == '0) state_d = S_DONE;
            S_DONE:  state_d = ctrl_shift ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        work_d   = work_q;
        amt_d    = amt_q;
        k_d      = k_q;
        result_d = result_q;
`ifdef SHIFTLEFT_OVF_EN
        loss_d   = loss_q;
`endif
        if (start_accept) begin
            work_d = data_operand;
            amt_d  = ctrl_shiftamt;
            k_d    = K_LAST;
`ifdef SHIFTLEFT_OVF_EN
            loss_d = 1'b0;
`endif
        end else if (state_q == S_SHIFT) begin
            work_d = stage_sel;
`ifdef SHIFTLEFT_OVF_EN
            loss_d = loss_q | stage_loss[k_q];
`endif
            if (k_q == '0) begin
                result_d = stage_sel;
            end else begin
                k_d = k_q - K_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            work_q   <= '0;
            amt_q    <= '0;
            k_q      <= K_LAST;
            result_q <= '0;
`ifdef SHIFTLEFT_OVF_EN
            loss_q   <= 1'b0;
`endif
        end else begin
            work_q   <= work_d;
            amt_q    <= amt_d;
            k_q      <= k_d;
            result_q <= result_d;
`ifdef SHIFTLEFT_OVF_EN
            loss_q   <= loss_d;
`endif
        end
    end

    // Output logic
    always_comb begin
        busy           = (state_q == S_SHIFT);
        data_resultRDY = (state_q == S_DONE);
        data_result    = result_q;
`ifdef SHIFTLEFT_OVF_EN
        data_exception = (state_q == S_DONE) && loss_q;
`endif
    end

endmodule

// File: tb/tb_shiftleft_iterative.sv
// Self-checking bench for shiftleft_iterative: directed vector table, multi-cycle corner sequences, random ops vs. an arithmetic model.
module tb_shiftleft_iterative;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_shift;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;
`ifdef SHIFTLEFT_OVF_EN
    logic        data_exception;
`endif

    int total = 0;
    int bad   = 0;

    shiftleft_iterative #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_shift     (ctrl_shift),
        .data_operand   (data_operand),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
`ifdef SHIFTLEFT_OVF_EN
        ,
        .data_exception (data_exception)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] op;
        logic [4:0]  amt;
        logic [31:0] exp;
        logic        exc;
    } vec_t;

    // Reference: multiply by 2**amt in 64 bits, keep low word; anything in the high word was lost.
    function automatic logic [31:0] model_shift(logic [31:0] op, logic [4:0] amt);
        logic [63:0] wide;
        wide = 64'(op) * (64'd2 ** amt);
        return wide[31:0];
    endfunction

    function automatic logic model_loss(logic [31:0] op, logic [4:0] amt);
        logic [63:0] wide;
        wide = 64'(op) * (64'd2 ** amt);
        return wide[63:32] != 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; the start is sampled at the following posedge (edge N).
    task automatic run_op(input string tag, input logic [31:0] op, input logic [4:0] amt,
                          input logic [31:0] exp, input logic exp_exc);
        logic [31:0] prev;
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          busy_cycles;
        logic        held;
        prev = data_result;
        ctrl_shift = 1'b1; data_operand = op; ctrl_shiftamt = amt;
        @(negedge clock);
        ctrl_shift = 1'b0; data_operand = $urandom; ctrl_shiftamt = 5'($urandom);
        lat = -1; busy_cycles = 0; held = 1'b1; res = 'x; exc = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) @(negedge clock);
            if (data_resultRDY) begin
                lat = i;
                res = data_result;
`ifdef SHIFTLEFT_OVF_EN
                exc = data_exception;
`endif
                break;
            end
            if (busy) busy_cycles++;
            if (data_result !== prev) held = 1'b0;
        end
        $display("op %s: operand=0x%08h shamt=%0d result=0x%08h latency=%0d", tag, op, amt, res, lat);
        check({tag, ".latency"}, 32'(lat), 32'd5);
        check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'd5);
        check({tag, ".held"}, 32'(held), 32'd1);
        check({tag, ".result"}, res, exp);
`ifdef SHIFTLEFT_OVF_EN
        check({tag, ".exception"}, 32'(exc), 32'(exp_exc));
`else
        exc = exp_exc;
`endif
        @(negedge clock);
        check({tag, ".rdy_pulse"}, {30'd0, data_resultRDY, busy}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int          cnt;
        int          gap;
        logic [31:0] r_op;
        logic [4:0]  r_amt;

        vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[1] = '{32'h1234_5678, 5'd8,  32'h3456_7800, 1'b1};
        vecs[2] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{32'h00FF_FFFF, 5'd8,  32'hFFFF_FF00, 1'b0};
        vecs[4] = '{32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1};
        vecs[6] = '{32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1};

        reset = 1'b1; ctrl_shift = 1'b1; data_operand = 32'hFFFF_FFFF; ctrl_shiftamt = 5'd3;
        repeat (3) @(negedge clock);
        $display("reset: result=0x%08h rdy=%0b busy=%0b", data_result, data_resultRDY, busy);
        check("reset.result", data_result, 32'd0);
        check("reset.rdy_busy", {30'd0, data_resultRDY, busy}, 32'd0);
        ctrl_shift = 1'b0;
        reset = 1'b0;
        @(negedge clock);

        for (int v = 0; v < 7; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].amt, vecs[v].exp, vecs[v].exc);
        end

        // Start while busy is ignored.
        ctrl_shift = 1'b1; data_operand = 32'h0000_000F; ctrl_shiftamt = 5'd4;
        @(negedge clock); ctrl_shift = 1'b0;
        @(negedge clock); ctrl_shift = 1'b1; data_operand = 32'hFFFF_FFFF; ctrl_shiftamt = 5'd1;
        @(negedge clock); ctrl_shift = 1'b0;
        gap = -1;
        for (int i = 3; i <= 12; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin gap = i; break; end
        end
        $display("ignore: result=0x%08h rdy_at=%0d", data_result, gap);
        check("ignore.latency", 32'(gap), 32'd5);
        check("ignore.result", data_result, 32'h0000_00F0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (data_resultRDY || busy || data_result !== 32'h0000_00F0) cnt++;
        end
        check("ignore.quiet_after", 32'(cnt), 32'd0);

        // Reset in the middle of an operation.
        ctrl_shift = 1'b1; data_operand = 32'h0000_0003; ctrl_shiftamt = 5'd2;
        @(negedge clock); ctrl_shift = 1'b0;
        @(negedge clock);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        $display("midreset: result=0x%08h rdy=%0b busy=%0b", data_result, data_resultRDY, busy);
        check("midreset.result", data_result, 32'd0);
        check("midreset.rdy_busy", {30'd0, data_resultRDY, busy}, 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (data_resultRDY || busy) cnt++;
        end
        check("midreset.no_rdy", 32'(cnt), 32'd0);
        run_op("after_reset", 32'h1, 5'd3, 32'h0000_0008, 1'b0);

        // Back-to-back: second start presented in the DONE cycle.
        ctrl_shift = 1'b1; data_operand = 32'h1; ctrl_shiftamt = 5'd1;
        @(negedge clock); ctrl_shift = 1'b0;
        gap = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin gap = i; break; end
        end
        check("b2b.first_latency", 32'(gap), 32'd5);
        check("b2b.first_result", data_result, 32'h2);
        ctrl_shift = 1'b1; data_operand = 32'h1; ctrl_shiftamt = 5'd2;
        gap = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            ctrl_shift = 1'b0;
            if (data_resultRDY) begin gap = i; break; end
        end
        $display("b2b: second result=0x%08h gap=%0d", data_result, gap);
        check("b2b.gap", 32'(gap), 32'd6);
        check("b2b.second_result", data_result, 32'h4);
        @(negedge clock);

        for (int n = 0; n < 40; n++) begin
            r_op  = $urandom;
            r_amt = 5'($urandom_range(0, 31));
            if (n % 5 == 0) r_op = r_op >> $urandom_range(0, 31);
            run_op($sformatf("rnd%0d", n), r_op, r_amt, model_shift(r_op, r_amt), model_loss(r_op, r_amt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
